sevenseg_scan_controller: RTL and testbench
===========================================

Name: sevenseg_scan_controller

Overview:
- Time-multiplexes one shared 4-bit-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Drives the decoder's nibble input, registers its segment output, and sequences the digit enables with a dead-time gap between digits to prevent ghosting.
- New display values arrive over a valid/ready handshake and swap in only at frame boundaries, so no frame ever shows a mix of old and new digits.
- Sits between the application datapath and the board's segment and anode pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clk cycles each digit is lit (SHOW length); minimum 2.
- BLANK_CYCLES, 16, clk cycles with all digits off between digits (GAP length); 0 means GAP is skipped.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value_in  in  4*NUM_DIGITS  digit nibbles; digit 0 is bits [3:0], the least significant (rightmost) digit.
- value_valid  in  1  value_in is offered.
- value_ready  out  1  a value can be accepted this cycle.
- blank_lz  in  1  enables leading-zero blanking.
- nibble_out  out  4  to the shared decoder's num input.
- seg_in  in  8  from the shared decoder's segments output; active-low, bit 7 = dp.
- seg_out  out  8  active-low segment pins, registered.
- digit_en_n  out  NUM_DIGITS  active-low digit anode enables, registered.
- frame_done  out  1  one-cycle pulse at the end of the last digit's SHOW.

Behaviour:
Clock and reset:
- Single clock domain.
- Reset is synchronous and active-high.
- Reset values: state=GAP, idx=0, cycle counter=0, display reg=0, pending reg empty, value_ready=1, seg_out=8'hFF, digit_en_n=all 1s, frame_done=0.
- Reset asserted mid-operation discards the pending value and restarts the scan from GAP, digit 0, on the next edge.

Handshake:
- A transfer occurs when value_valid && value_ready.
- The accepted value goes into the pending reg; value_ready drops to 0 on the following cycle.
- Pending moves to the display reg on the frame_done cycle; value_ready returns to 1 on the next cycle.
- Because value_ready=0 whenever pending is full, accept and transfer can never coincide.
- If pending is empty at frame end, the display reg holds its value.

Datapath:
- nibble_out is combinational: display_reg[4*idx +: 4].

State machine:
- GAP:
  - seg_out<=8'hFF, digit_en_n<=all 1s.
  - Counts BLANK_CYCLES cycles, then moves to SHOW.
  - With BLANK_CYCLES=0, GAP takes zero cycles and SHOW follows SHOW directly.
- SHOW:
  - Every cycle: seg_out<=seg_in (one-cycle latency from nibble_out), and digit_en_n<=one-hot-low at idx.
  - After REFRESH_DIV cycles: idx<=idx+1, wrapping NUM_DIGITS-1 -> 0, and state goes to GAP.
  - frame_done=1 in the final SHOW cycle of idx=NUM_DIGITS-1.
- Frame length: NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Counter width is clog2 of max(REFRESH_DIV, BLANK_CYCLES)+1; the counter clears on every state change.

Leading-zero blanking:
- Applies when blank_lz=1.
- Digit i>0 is blanked if its nibble and every higher digit's nibble are all 0.
- A blanked digit keeps SHOW timing but drives seg_out=8'hFF with digit_en_n all 1s.
- Digit 0 is never blanked.
- blank_lz is sampled live.

Optional Feature:
- Macro: SEVENSEG_SCAN_DP_EN.
- Enabled:
  - Adds port dp_in (in, NUM_DIGITS, active-high decimal points).
  - dp_in is captured into pending/display alongside value_in using the same handshake.
  - In SHOW, seg_out[7]<=~dp_reg[idx].
  - A blanked digit shows no dp.
- Disabled:
  - No dp_in port.
  - seg_out[7] passes seg_in[7] in SHOW.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, with a real decoder in the loop.
1. Assert reset for 3 cycles -> seg_out=8'hFF, digit_en_n=4'b1111, value_ready=1, frame_done=0; first SHOW (digit 0, display 0) begins 2 cycles after reset release, showing seg_out=8'hC0 and digit_en_n=4'b1110.
2. Offer value_in=16'h12AF for one cycle -> value_ready=0 next cycle; the current frame still shows 0000; after frame_done, digit 0 shows 8'h8E (F), digit 1 shows 8'h88 (A), digit 2 shows 8'hA4, and digit 3 shows 8'hF9 with digit_en_n=4'b0111; value_ready=1 again.
3. Free-run -> frame_done pulses exactly every 40 cycles; each digit lit for 8 cycles; 2-cycle all-off gap between digits; never two enables low at once.
4. Set blank_lz=1 with value 16'h0050 -> digits 3 and 2 dark; digit 1 shows 8'h92; digit 0 shows 8'hC0. With value 16'h0000 -> only digit 0 lit, showing 8'hC0.
5. Hold value_valid=1 with 16'h1111, then 16'h2222, back-to-back -> 2222 is not accepted until the cycle after the frame_done that loads 1111; 1111 is displayed for one full frame.
6. Assert reset in the 4th SHOW cycle of digit 2 with pending full -> pending discarded, outputs at reset values next edge, display reverts to 0000. With SEVENSEG_SCAN_DP_EN and dp_in=4'b0010 -> only digit 1 has seg_out[7]=0.

Source files
------------

// File: rtl/sevenseg_scan_controller.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_controller
//
// Purpose:
//   Time-multiplexes one shared 4-bit-to-7-segment decoder across NUM_DIGITS
//   common-anode digits. The controller selects the nibble of the digit being
//   scanned, registers the decoder's segment pattern, and sequences the
//   active-low anode enables with an all-off gap between digits so the previous
//   digit's pattern never ghosts onto the next one. New display values are
//   taken over a valid/ready handshake into a pending register and swapped into
//   the display register only at the end of a frame, so every frame shows one
//   consistent value.
//
// Parameters:
//   NUM_DIGITS   : digits scanned, 1..8
//   REFRESH_DIV  : clk cycles each digit is lit (>= 2)
//   BLANK_CYCLES : clk cycles with all digits off between digits (0 = no gap)
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   value_in     in   [4*NUM_DIGITS] digit nibbles, digit 0 in bits [3:0]
//   value_valid  in   value_in is offered
//   value_ready  out  a value can be accepted this cycle
//   blank_lz     in   leading-zero blanking enable (sampled live)
//   dp_in        in   [NUM_DIGITS] active-high decimal points (optional)
//   nibble_out   out  [4] to the shared decoder's num input
//   seg_in       in   [8] from the shared decoder, active-low, bit 7 = dp
//   seg_out      out  [8] active-low segment pins, registered
//   digit_en_n   out  [NUM_DIGITS] active-low anode enables, registered
//   frame_done   out  one-cycle pulse in the last SHOW cycle of the last digit
//
// Optional feature:
//   Define SEVENSEG_SCAN_DP_EN to add the dp_in port. Decimal points are then
//   captured with value_in and drive seg_out[7]; otherwise seg_out[7] follows
//   the decoder's seg_in[7].
// -----------------------------------------------------------------------------
module sevenseg_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    value_valid,
   output logic                    value_ready,
   input  logic                    blank_lz,
`ifdef SEVENSEG_SCAN_DP_EN
   input  logic [NUM_DIGITS-1:0]   dp_in,
`endif
   output logic [3:0]              nibble_out,
   input  logic [7:0]              seg_in,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   digit_en_n,
   output logic                    frame_done
);

   localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] SHOW_PRE  = CNT_W'(REFRESH_DIV - 2);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      ST_GAP  = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   // Scan state
   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   // Value path
   logic [4*NUM_DIGITS-1:0] display_q, display_d;
   logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
   logic                    pending_full_q, pending_full_d;
   logic                    accept;

   // Registered pin outputs
   logic [7:0]              seg_out_q, seg_out_d;
   logic [NUM_DIGITS-1:0]   digit_en_n_q, digit_en_n_d;
   logic                    frame_done_q, frame_done_d;

   // Per-digit decode of the current scan position
   logic [3:0]              cur_nibble;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    lz_run;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   en_lit;

`ifdef SEVENSEG_SCAN_DP_EN
   logic [NUM_DIGITS-1:0]   dp_disp_q, dp_disp_d;
   logic [NUM_DIGITS-1:0]   dp_pend_q, dp_pend_d;
   logic                    cur_dp;
`endif

   // --------------------------------------------------------------------------
   // Digit selection and leading-zero detection
   // --------------------------------------------------------------------------
   always_comb begin
      cur_nibble = 4'h0;
      en_lit     = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nibble = display_q[4*i +: 4];
            en_lit[i]  = 1'b0;
         end
      end
   end

   // Walk from the most significant digit down: a digit is a leading zero
   // while it and everything above it are zero. Digit 0 always stays lit so
   // a value of zero still shows a single "0".
   always_comb begin
      lz_mask = '0;
      lz_run  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lz_run = lz_run & (display_q[4*i +: 4] == 4'h0);
         if (i != 0) begin
            lz_mask[i] = lz_run;
         end
      end
   end

   always_comb begin
      cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_blank = blank_lz & lz_mask[i];
         end
      end
   end

`ifdef SEVENSEG_SCAN_DP_EN
   always_comb begin
      cur_dp = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_dp = dp_disp_q[i];
         end
      end
   end
`endif

   assign nibble_out = cur_nibble;

   // --------------------------------------------------------------------------
   // Handshake and frame-boundary swap
   // --------------------------------------------------------------------------
   // pending_full blocks value_ready, so a new accept can never land in the
   // same cycle as the pending-to-display transfer.
   assign accept      = value_valid & ~pending_full_q;
   assign value_ready = ~pending_full_q;

   always_comb begin
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      display_d      = display_q;
`ifdef SEVENSEG_SCAN_DP_EN
      dp_pend_d      = dp_pend_q;
      dp_disp_d      = dp_disp_q;
`endif
      if (frame_done_q && pending_full_q) begin
         display_d      = pending_q;
         pending_full_d = 1'b0;
`ifdef SEVENSEG_SCAN_DP_EN
         dp_disp_d      = dp_pend_q;
`endif
      end
      if (accept) begin
         pending_d      = value_in;
         pending_full_d = 1'b1;
`ifdef SEVENSEG_SCAN_DP_EN
         dp_pend_d      = dp_in;
`endif
      end
   end

   // --------------------------------------------------------------------------
   // Scan sequencer: GAP (all off) -> SHOW (one digit lit) -> next digit
   // --------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q + CNT_W'(1);
      seg_out_d    = 8'hFF;
      digit_en_n_d = '1;

      // frame_done is registered, so it is raised one cycle early: it is high
      // exactly while the last digit sits in its final SHOW cycle.
      frame_done_d = (state_q == ST_SHOW) && (cnt_q == SHOW_PRE) && (idx_q == IDX_LAST);

      case (state_q)
         ST_GAP: begin
            if ((BLANK_CYCLES == 0) || (cnt_q == GAP_LAST)) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
            end
         end

         ST_SHOW: begin
            if (!cur_blank) begin
               seg_out_d = seg_in;
`ifdef SEVENSEG_SCAN_DP_EN
               seg_out_d[7] = ~cur_dp;
`endif
               digit_en_n_d = en_lit;
            end
            if (cnt_q == SHOW_LAST) begin
               idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
               state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_GAP;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = ST_GAP;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_GAP;
         idx_q          <= '0;
         cnt_q          <= '0;
         display_q      <= '0;
         pending_full_q <= 1'b0;
         seg_out_q      <= 8'hFF;
         digit_en_n_q   <= '1;
         frame_done_q   <= 1'b0;
`ifdef SEVENSEG_SCAN_DP_EN
         dp_disp_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         display_q      <= display_d;
         pending_full_q <= pending_full_d;
         seg_out_q      <= seg_out_d;
         digit_en_n_q   <= digit_en_n_d;
         frame_done_q   <= frame_done_d;
`ifdef SEVENSEG_SCAN_DP_EN
         dp_disp_q      <= dp_disp_d;
`endif
      end
   end

   // Pending data is only meaningful while pending_full_q is set.
   always_ff @(posedge clk) begin
      pending_q <= pending_d;
`ifdef SEVENSEG_SCAN_DP_EN
      dp_pend_q <= dp_pend_d;
`endif
   end

   assign seg_out    = seg_out_q;
   assign digit_en_n = digit_en_n_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_controller
//
// Directed bench for sevenseg_scan_controller with NUM_DIGITS=4,
// REFRESH_DIV=8, BLANK_CYCLES=2 and a hex-to-7-segment decoder in the loop.
// Frame timing relative to a frame_done cycle F (sampled on negedge):
//   digit k is lit at F+4+10k .. F+11+10k, all-off otherwise, next
//   frame_done at F+40.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_controller;

   localparam int N = 4;
   localparam int R = 8;
   localparam int B = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value_in;
   logic        value_valid;
   logic        value_ready;
   logic        blank_lz;
   logic [3:0]  nibble_out;
   logic [7:0]  seg_in;
   logic [7:0]  seg_out;
   logic [3:0]  digit_en_n;
   logic        frame_done;
`ifdef SEVENSEG_SCAN_DP_EN
   logic [3:0]  dp_in;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int rdy;

   always #5 clk = ~clk;

   sevenseg_scan_controller #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (R),
      .BLANK_CYCLES(B)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .value_in   (value_in),
      .value_valid(value_valid),
      .value_ready(value_ready),
      .blank_lz   (blank_lz),
`ifdef SEVENSEG_SCAN_DP_EN
      .dp_in      (dp_in),
`endif
      .nibble_out (nibble_out),
      .seg_in     (seg_in),
      .seg_out    (seg_out),
      .digit_en_n (digit_en_n),
      .frame_done (frame_done)
   );

   // Shared decoder: active-low segments, dp (bit 7) off.
   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
         4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
         4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
         4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
      endcase
   endfunction

   assign seg_in = hex7(nibble_out);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Called on negedge F+from-1; walks to F+40 checking every cycle against the
   // expected per-digit pattern (segs = {d3,d2,d1,d0}; 8'hFF = digit dark).
   task automatic scan(input int from, input logic [31:0] segs, input string tag,
                       output int rdy_cnt);
      int         errs;
      int         fd_bad;
      int         k;
      logic [7:0] es;
      logic [3:0] een;
      errs    = 0;
      fd_bad  = 0;
      rdy_cnt = 0;
      for (int off = from; off <= 40; off++) begin
         @(negedge clk);
         k = -1;
         for (int d = 0; d < 4; d++)
            if (off >= 4 + 10*d && off <= 11 + 10*d) k = d;
         if (k >= 0) begin
            es  = segs[8*k +: 8];
            een = (es == 8'hFF) ? 4'hF : ~(4'b0001 << k);
         end else begin
            es  = 8'hFF;
            een = 4'hF;
         end
         if (seg_out !== es || digit_en_n !== een) errs++;
         if (frame_done !== (off == 40)) fd_bad++;
         if (value_ready === 1'b1) rdy_cnt++;
      end
      check({tag, "_pattern_errs"}, errs, 0);
      check({tag, "_fd_placement"}, fd_bad, 0);
   endtask

   task automatic wait_fd(input string tag);
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_fd_seen"}, frame_done, 1'b1);
   endtask

   initial begin
      reset       = 1'b1;
      value_in    = 16'h0000;
      value_valid = 1'b0;
      blank_lz    = 1'b0;
`ifdef SEVENSEG_SCAN_DP_EN
      dp_in       = 4'b0000;
`endif

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_seg", seg_out, 8'hFF);
      check("rst_en", digit_en_n, 4'hF);
      check("rst_ready", value_ready, 1'b1);
      check("rst_fd", frame_done, 1'b0);

      // First SHOW after release: GAP for 2 cycles, seg registered one later
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("boot_gap_en", digit_en_n, 4'hF);
      @(negedge clk);
      check("boot_seg", seg_out, 8'hC0);
      check("boot_en", digit_en_n, 4'b1110);

      // Free-run frame with display 0000
      wait_fd("t3");
      @(negedge clk);
      scan(2, 32'hC0C0C0C0, "free", rdy);
      check("free_ready", rdy, 39);

      // Load 12AF: current frame stays 0000, next frame shows it
      value_in    = 16'h12AF;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      check("ld_ready_low", value_ready, 1'b0);
      scan(2, 32'hC0C0C0C0, "ld_old", rdy);
      check("ld_old_ready", rdy, 0);
      @(negedge clk);
      check("ld_ready_back", value_ready, 1'b1);
      scan(2, 32'hF9A4888E, "ld_new", rdy);
      check("ld_new_ready", rdy, 39);

      // Leading-zero blanking: 0050 then 0000
      value_in    = 16'h0050;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      blank_lz    = 1'b1;
      scan(2, 32'hF9A4888E, "lz_old", rdy);
      @(negedge clk);
      scan(2, 32'hFFFF92C0, "lz_0050", rdy);
      value_in    = 16'h0000;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      scan(2, 32'hFFFF92C0, "lz_hold", rdy);
      @(negedge clk);
      scan(2, 32'hFFFFFFC0, "lz_0000", rdy);
      blank_lz = 1'b0;

      // Back-to-back offers: 2222 waits until the cycle after 1111 loads
      value_in    = 16'h1111;
      value_valid = 1'b1;
      @(negedge clk);
      value_in = 16'h2222;
      check("b2b_ready_low", value_ready, 1'b0);
      scan(2, 32'hC0C0C0C0, "b2b_f0", rdy);
      check("b2b_f0_ready", rdy, 0);
      @(negedge clk);
      check("b2b_ready_up", value_ready, 1'b1);
      @(negedge clk);
      check("b2b_ready_relow", value_ready, 1'b0);
      value_valid = 1'b0;
      scan(3, 32'hF9F9F9F9, "b2b_1111", rdy);
      check("b2b_1111_ready", rdy, 0);
      @(negedge clk);
      scan(2, 32'hA4A4A4A4, "b2b_2222", rdy);
      check("b2b_2222_ready", rdy, 40 - 1);

      // Reset in the 4th SHOW cycle of digit 2 with pending full
      value_in    = 16'h1234;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      repeat (25) @(negedge clk);
      check("mid_pre_en", digit_en_n, 4'b1011);
      check("mid_pre_seg", seg_out, 8'hA4);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_seg", seg_out, 8'hFF);
      check("mid_rst_en", digit_en_n, 4'hF);
      check("mid_rst_ready", value_ready, 1'b1);
      check("mid_rst_fd", frame_done, 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_gap_en", digit_en_n, 4'hF);
      @(negedge clk);
      check("mid_boot_seg", seg_out, 8'hC0);
      check("mid_boot_en", digit_en_n, 4'b1110);
      wait_fd("mid");
      @(negedge clk);
      scan(2, 32'hC0C0C0C0, "mid_after", rdy);
      check("mid_after_ready", rdy, 39);

`ifdef SEVENSEG_SCAN_DP_EN
      // Decimal point on digit 1 only
      dp_in       = 4'b0010;
      value_in    = 16'h0000;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      dp_in       = 4'b0000;
      scan(2, 32'hC0C0C0C0, "dp_old", rdy);
      @(negedge clk);
      scan(2, 32'hC0C040C0, "dp_new", rdy);
      check("dp_new_ready", rdy, 39);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
